// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: opcode constants, fetch-state encoding and link register index
package pc_sequencer_pkg;
  localparam logic [5:0] OP_B    = 6'b101000;
  localparam logic [5:0] OP_BR   = 6'b100000;
  localparam logic [5:0] OP_BLTZ = 6'b110000;
  localparam logic [5:0] OP_BZ   = 6'b110001;
  localparam logic [5:0] OP_BNZ  = 6'b110010;
  localparam logic [5:0] OP_BCY  = 6'b101001;
  localparam logic [5:0] OP_BNCY = 6'b101010;
  localparam logic [5:0] OP_BL   = 6'b101011;
  localparam int LINK_REG = 31;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_STALL = 2'd1, ST_HALT = 2'd2} state_e;
endpackage

// File: rtl/pc_sequencer_target_calc.sv
// pc_target_calc: branch target (op_i/offset_i/rs_value_i/id_pc_i in, target_o out); br uses rs, others id_pc+sext(offset)
module pc_target_calc
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int OFF_W = 26
) (
  input  logic [5:0]      op_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [PC_W-1:0] rs_value_i,
  input  logic [PC_W-1:0] id_pc_i,
  output logic [PC_W-1:0] target_o
);
  logic [PC_W-1:0] off_ext;
  always_comb begin
    off_ext  = {{(PC_W-OFF_W){offset_i[OFF_W-1]}}, offset_i};
    target_o = op_i == OP_BR ? rs_value_i : id_pc_i + off_ext;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, RUN/STALL/HALT fetch state, flush/link pulses and redirect count; ports: clk,rst_n,stall,halt_req,resume,OPcode,br_taken,offset,rs_value,id_pc in; pc,flush,link_we,link_data,halted,taken_cnt out
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              OFF_W    = 26,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  input  logic [5:0]        OPcode,
  input  logic              br_taken,
  input  logic [OFF_W-1:0]  offset,
  input  logic [PC_W-1:0]   rs_value,
  input  logic [PC_W-1:0]   id_pc,
  output logic [PC_W-1:0]   pc,
  output logic              flush,
  output logic              link_we,
  output logic [PC_W-1:0]   link_data,
  output logic              halted,
  output logic [CNT_W-1:0]  taken_cnt
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, link_data_q, link_data_d, target;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic flush_q, flush_d, link_we_q, link_we_d, hold, apply;
  pc_target_calc #(.PC_W(PC_W), .OFF_W(OFF_W)) u_target (
    .op_i(OPcode), .offset_i(offset), .rs_value_i(rs_value), .id_pc_i(id_pc), .target_o(target)
  );
  always_comb begin
    hold        = state_q == ST_HALT || stall;
    apply       = !hold && br_taken;
    state_d     = state_q == ST_HALT ? (resume ? ST_RUN : ST_HALT) :
                  halt_req ? ST_HALT : stall ? ST_STALL : ST_RUN;
    pc_d        = hold ? pc_q : br_taken ? target : pc_q + PC_W'(1);
    flush_d     = apply;
    link_we_d   = apply && OPcode == OP_BL;
    link_data_d = link_we_d ? id_pc + PC_W'(1) : link_data_q;
    cnt_d       = apply ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      flush_q     <= 1'b0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
      cnt_q       <= cnt_d;
    end
  end
  assign pc        = pc_q;
  assign flush     = flush_q;
  assign link_we   = link_we_q;
  assign link_data = link_data_q;
  assign halted    = state_q == ST_HALT;
  assign taken_cnt = cnt_q;
endmodule
